// File: rtl/pcm_sample_packer.sv
// PCM sample packer: optional DC block, shift + saturate to 16 bits, pack two samples per word, FIFO out.
// Optional DC-blocking high-pass is compiled in with `define DC_BLOCK_EN.
module pcm_sample_packer #(
  parameter int IN_WIDTH       = 32,
  parameter int SHIFT          = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int DC_ALPHA_SHIFT = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic                          in_valid,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [IN_WIDTH-1:0] SMAX = IN_WIDTH'(32767);
  localparam logic signed [IN_WIDTH-1:0] SMIN = IN_WIDTH'(-32768);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  logic                       accept;
  logic signed [IN_WIDTH-1:0] x;

  assign accept = in_valid & enable;

`ifdef DC_BLOCK_EN
  localparam int ACC_W = IN_WIDTH + DC_ALPHA_SHIFT;
  localparam logic signed [IN_WIDTH:0] XMAX = {2'b00, {(IN_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] XMIN = {2'b11, {(IN_WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  dc;
  logic signed [IN_WIDTH:0] diff;

  // dc always fits in IN_WIDTH signed bits, so its low IN_WIDTH+1 bits are a valid sign extension
  always_comb begin
    dc   = acc >>> DC_ALPHA_SHIFT;
    diff = $signed({in_data[IN_WIDTH-1], in_data}) - $signed(dc[IN_WIDTH:0]);
    if (diff > XMAX)      x = XMAX[IN_WIDTH-1:0];
    else if (diff < XMIN) x = XMIN[IN_WIDTH-1:0];
    else                  x = diff[IN_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)         acc <= '0;
    else if (accept) acc <= acc + $signed({{DC_ALPHA_SHIFT{x[IN_WIDTH-1]}}, x});
  end
`else
  if (DC_ALPHA_SHIFT < 0) begin : g_bad_alpha
    $error("DC_ALPHA_SHIFT must be non-negative");
  end
  assign x = in_data;
`endif

  // Stage 1: capture (possibly DC-blocked) sample
  logic                       s1_vld;
  logic signed [IN_WIDTH-1:0] s1_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_x   <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_x <= x;
    end
  end

  // Stage 2: arithmetic shift and saturate to signed 16
  logic signed [IN_WIDTH-1:0] y;
  logic [15:0]                y_sat;
  logic                       s2_vld;
  logic [15:0]                s2_y;

  always_comb begin
    y = s1_x >>> SHIFT;
    if (y > SMAX)      y_sat = 16'h7fff;
    else if (y < SMIN) y_sat = 16'h8000;
    else               y_sat = y[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_y   <= '0;
    end else begin
      s2_vld <= s1_vld;
      s2_y   <= y_sat;
    end
  end

  // Packer and FIFO
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          pack_phase;
  logic [15:0]   low_half;
  logic          empty, full, pop, push_req, do_push, drop;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_level = wr_ptr - rd_ptr;
  assign out_valid  = ~empty;
  assign out_data   = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
  assign pop        = ~empty & out_ready;
  // enable=0 holds the packer idle; in-flight samples drain out of stage 2 without being packed
  assign push_req   = s2_vld & enable & pack_phase;
  assign do_push    = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= {s2_y, low_half};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pack_phase <= 1'b0;
      low_half   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (!enable) begin
        pack_phase <= 1'b0;
      end else if (s2_vld) begin
        pack_phase <= ~pack_phase;
        if (!pack_phase) low_half <= s2_y;
      end
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pcm_sample_packer.sv
// Scoreboard bench for pcm_sample_packer: expected words queued at stimulus time, compared on drain.
module tb_pcm_sample_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        clear_overflow;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pcm_sample_packer #(.IN_WIDTH(32), .SHIFT(8), .FIFO_DEPTH(16), .DC_ALPHA_SHIFT(10)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  function automatic logic [15:0] sat16(input logic [31:0] s);
    logic signed [31:0] v;
    v = $signed(s) >>> 8;
    if (v > 32767)       return 16'h7fff;
    else if (v < -32768) return 16'h8000;
    else                 return v[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] s);
    in_data  = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pair(input logic [31:0] a, input logic [31:0] b);
    send(a);
    send(b);
    exp_q.push_back({sat16(b), sat16(a)});
  endtask

  task automatic drain(input int max_cycles);
    logic [31:0] e;
    out_ready = 1'b1;
    for (int c = 0; c < max_cycles && exp_q.size() > 0; c++) begin
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL drain_valid: got %b want 1 (pending %0d)", out_valid, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e) begin
          failures++;
          $display("FAIL drain_data: got %h want %h", out_data, e);
        end
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d words left want 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin
      failures++;
      $display("FAIL drain_empty: got valid=%b level=%0d want 0/0", out_valid, fifo_level);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h0012_3400;
    tick(); tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || fifo_level !== 5'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%0d o=%b want 0/0/0/0", out_valid, out_data, fifo_level, overflow);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (fifo_level !== 5'd0) begin
      failures++;
      $display("FAIL reset_ignores_valid: got level %0d want 0", fifo_level);
    end
  endtask

  task automatic test_basic();
    send(32'h0000_1200);
    send(32'h0000_3400);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_k: got %b want 0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_k1: got %b want 0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || fifo_level !== 5'd1) begin
      failures++;
      $display("FAIL latency_k2: got v=%b l=%0d want 1/1", out_valid, fifo_level);
    end
    exp_q.push_back(32'h0034_0012);
    drain(4);
  endtask

  task automatic test_saturation();
    send(32'h00FF_FFFF);
    send(32'hFF00_0000);
    exp_q.push_back(32'h8000_7FFF);
    send(32'hFFFF_FF00);
    send(32'h0000_0000);
    exp_q.push_back(32'h0000_FFFF);
    for (int i = 0; i < 4; i++) pair($urandom, $urandom);
    tick(); tick(); tick();
    checks++;
    if (fifo_level !== 5'd6) begin failures++; $display("FAIL sat_level: got %0d want 6", fifo_level); end
    drain(10);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) pair($urandom_range(0, 32'h00FF_FFFF) - 32'h0080_0000, $urandom);
    tick(); tick(); tick();
    checks++;
    if (fifo_level !== 5'd10) begin failures++; $display("FAIL b2b_level: got %0d want 10", fifo_level); end
    drain(14);
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) pair($urandom, $urandom);
    tick(); tick(); tick();
    checks++;
    if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_level: got l=%0d o=%b want 16/0", fifo_level, overflow);
    end
    send(32'h0000_5500);
    send(32'h0000_6600);
    tick(); tick(); tick();
    checks++;
    if (overflow !== 1'b1 || fifo_level !== 5'd16) begin
      failures++;
      $display("FAIL overflow_set: got o=%b l=%0d want 1/16", overflow, fifo_level);
    end
    checks++;
    if (out_data !== exp_q[0]) begin failures++; $display("FAIL overflow_head: got %h want %h", out_data, exp_q[0]); end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear: got %b want 0", overflow); end
    // full FIFO with a pop in the very cycle of the push
    send(32'h0000_7700);
    send(32'h0000_8800);
    tick();
    out_ready = 1'b1;
    w = exp_q.pop_front();
    checks++;
    if (out_data !== w) begin failures++; $display("FAIL fullpop_head: got %h want %h", out_data, w); end
    tick();
    out_ready = 1'b0;
    exp_q.push_back(32'h0088_0077);
    checks++;
    if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_level: got l=%0d o=%b want 16/0", fifo_level, overflow);
    end
    drain(20);
  endtask

  task automatic test_enable();
    send(32'h0000_0500);
    tick(); tick(); tick();
    enable = 1'b0;
    send(32'h0000_0700);
    tick(); tick(); tick();
    enable = 1'b1;
    send(32'h0000_0100);
    send(32'h0000_0200);
    tick(); tick(); tick();
    checks++;
    if (fifo_level !== 5'd1) begin failures++; $display("FAIL enable_level: got %0d want 1", fifo_level); end
    exp_q.push_back(32'h0002_0001);
    drain(4);
  endtask

  task automatic test_reset_mid();
    send(32'h0000_1100);
    tick();
    do_reset();
    send(32'h0000_0100);
    send(32'h0000_0300);
    tick(); tick(); tick();
    checks++;
    if (fifo_level !== 5'd1) begin failures++; $display("FAIL reset_mid_level: got %0d want 1", fifo_level); end
    exp_q.push_back(32'h0003_0001);
    drain(4);
  endtask

`ifdef DC_BLOCK_EN
  task automatic test_dc();
    logic signed [15:0] prev, h;
    do_reset();
    send(32'h0010_0000);
    send(32'h0010_0000);
    tick(); tick();
    checks++;
    if (out_data !== 32'h0FFC_1000) begin failures++; $display("FAIL dc_first: got %h want 0ffc1000", out_data); end
    prev = 16'sh0ffc;
    out_ready = 1'b1;
    tick();
    in_data = 32'h0010_0000;
    for (int i = 0; i < 8200; i++) begin
      in_valid = (i < 8190);
      if (out_valid) begin
        for (int k = 0; k < 2; k++) begin
          h = (k == 0) ? $signed(out_data[15:0]) : $signed(out_data[31:16]);
          checks++;
          if (h > prev || h < 0) begin
            failures++;
            $display("FAIL dc_decay: got %h after %h", h, prev);
          end
          prev = h;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (prev >= 16) begin failures++; $display("FAIL dc_final: got %h want below 0010", prev); end
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b1; in_data = '0; in_valid = 1'b0;
    out_ready = 1'b0; clear_overflow = 1'b0;
    test_reset();
`ifdef DC_BLOCK_EN
    test_dc();
`else
    test_basic();
    test_saturation();
    test_back_to_back();
    test_overflow();
    test_enable();
    test_reset_mid();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pcm_sample_packer.md
Name: pcm_sample_packer

Overview:
- Sits directly downstream of the PDM microphone front end and consumes its 32-bit decimated PCM sample stream (`in_data` / `in_valid`).
- Each sample is optionally DC-blocked, then arithmetically scaled and saturated to signed 16 bits.
- Two consecutive samples are packed into one 32-bit word and the word is buffered in a small FIFO.
- The FIFO is drained through a valid/ready interface towards the processor/DMA side.

Parameters:
- IN_WIDTH, 32: input PCM sample width, signed two's complement.
- SHIFT, 8: arithmetic right shift applied before saturation.
- FIFO_DEPTH, 16: FIFO depth in 32-bit words; must be a power of 2 and at least 2.
- DC_ALPHA_SHIFT, 10: DC-estimator time constant, 2^DC_ALPHA_SHIFT samples. Used only with DC_BLOCK_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  accept input samples when high
- in_data  in  IN_WIDTH  signed PCM sample from the decimator
- in_valid  in  1  single-cycle strobe; no backpressure, the sample must be taken or dropped
- out_data  out  32  packed word {sample_odd[15:0], sample_even[15:0]}
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts out_data this cycle
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently stored
- overflow  out  1  sticky: a packed word was dropped because the FIFO was full
- clear_overflow  in  1  clears overflow

Behaviour:
- Reset (clk, rst synchronous active-high):
  - Empties the FIFO, clears pack phase, DC accumulator and all pipeline registers.
  - Outputs after reset: out_valid=0, out_data=0, fifo_level=0, overflow=0.
  - in_valid is ignored while rst=1. Reset mid-operation discards all stored data, including a pending half-word.
- Stage 1 (edge k, in_valid=1 and enable=1): x = in_data, or the DC-blocked value (see Optional Feature). The stage-1 valid flag is registered.
- Stage 2 (edge k+1):
  - y = x >>> SHIFT (sign-preserving).
  - Saturate y to signed 16 bits: y > 32767 gives 0x7FFF; y < -32768 gives 0x8000; otherwise y[15:0].
- Packer (edge k+2):
  - pack_phase=0: store the sample in low_half, set pack_phase=1.
  - pack_phase=1: form the word {sample, low_half} and push it to the FIFO, set pack_phase=0.
  - The even (first) sample goes in bits [15:0].
- Latency: in_valid of the odd sample sampled at edge k gives out_valid=1 after edge k+2, provided the FIFO was empty.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address.
  - out_data = mem[rd_ptr] when not empty, 0 when empty. out_valid = !empty.
  - Pop on out_valid && out_ready.
  - Push while full without a pop: the word is dropped, overflow is set, pointers are unchanged, and the pack phase still toggles.
  - Push and pop in the same cycle while full: both are performed and fifo_level is unchanged.
  - Push and pop in the same cycle while empty: only the push happens, because out_valid was 0.
  - Pointers wrap modulo 2*FIFO_DEPTH.
  - fifo_level = wr_ptr - rd_ptr.
- overflow: cleared by clear_overflow. If a drop and clear_overflow occur in the same cycle, set wins.
- enable=0:
  - New in_valid strobes are ignored.
  - pack_phase is forced to 0 and any pending low_half is discarded.
  - Samples already in stages 1–2 still complete.
  - The FIFO continues to drain.
- in_valid strobes may arrive every cycle; the pipeline runs at full rate with no stalls.

Optional Feature:
- Macro: DC_BLOCK_EN.
- When defined:
  - Signed accumulator acc, IN_WIDTH+DC_ALPHA_SHIFT bits, reset to 0.
  - dc = acc >>> DC_ALPHA_SHIFT; x = in_data - dc, computed in IN_WIDTH+1 bits and saturated to IN_WIDTH.
  - On each accepted sample, acc <= acc + x.
  - Result: a first-order high-pass that removes microphone DC offset.
- When undefined: x = in_data, and no accumulator is instantiated.

Test Plan:
- Reset, macro off, samples 0x00001200 then 0x00003400 -> one word 0x00340012. out_valid rises 2 edges after the second strobe. fifo_level=1.
- Saturation: samples 0x00FFFFFF then 0xFF000000 -> word 0x80007FFF. Sample 0xFFFFFF00 yields 0xFFFF (-1).
- Overflow:
  - out_ready=0, feed 32 samples -> fifo_level=16.
  - Feed 2 more -> overflow=1, fifo_level=16, first word unchanged.
  - clear_overflow pulse -> overflow=0.
- Full with simultaneous pop: out_ready=1 in the push cycle -> fifo_level stays 16, overflow stays 0. Drained words appear in order with no gaps.
- Enable mid-pair: one sample, then enable=0, then enable=1, then samples 0x00000100 and 0x00000200 -> only word 0x00020001; the first sample is discarded.
- DC_BLOCK_EN defined:
  - Constant input 0x00100000 -> first packed word 0x0FFC1000.
  - Later outputs decay monotonically towards 0, reaching |y| < 0x0010 within 8192 samples.
